// File: rtl/tcm_enc_sched_pkg.sv
// Shared types and constants for the tcm_enc packet scheduler.
package tcm_enc_sched_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // 8PSK samples per 4D symbol slot; one data word is issued per slot
  localparam int unsigned cSYMB_PER_WORD = 4;

  typedef logic [1:0] code_t;

  // Information bits per 4D symbol for code 0..3
  localparam int unsigned cCODE_BITS [4] = '{8, 9, 10, 11};

endpackage

// File: rtl/tcm_enc_sched_if.sv
// Word path between the scheduler, its source and the tcm_enc encoder.
interface tcm_enc_sched_if
  import tcm_enc_sched_pkg::*;
#(
  parameter int unsigned pDAT_W = 11
) ();

  logic              ival;
  logic [pDAT_W-1:0] idat;
  logic              ordy;
  code_t             ocode;
  logic              o1sps;
  logic              osop;
  logic              oeop;
  logic              oval;
  logic [pDAT_W-1:0] odat;

  modport master (
    output ival, idat,
    input  ordy, ocode, o1sps, osop, oeop, oval, odat
  );

  modport slave (
    input  ival, idat,
    output ordy, ocode, o1sps, osop, oeop, oval, odat
  );

endinterface

// File: rtl/tcm_enc_sched_sps_strobe.sv
// Sample-rate divider and 4-phase symbol counter for tcm_enc_sched.
// Strobe fires when the divider is at 0; slot is the strobe at phase 0.
module tcm_sps_strobe
  import tcm_enc_sched_pkg::*;
#(
  parameter int unsigned pSPS_W = 8
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic [pSPS_W-1:0] isps_div,
  output logic              ostrobe,
  output logic              oslot
);

  logic [pSPS_W-1:0] cnt_q, cnt_d, div_q, lim;
  logic [1:0]        phase_q, phase_d;

  // Divider limit is sampled at count 0 so a new isps_div only applies from the next wrap
  always_comb begin
    lim     = (cnt_q == '0) ? isps_div : div_q;
    cnt_d   = (cnt_q == lim) ? '0 : cnt_q + pSPS_W'(1);
    phase_d = (phase_q == 2'(cSYMB_PER_WORD - 1)) ? '0 : phase_q + 2'd1;
    ostrobe = iclkena & (cnt_q == '0);
    oslot   = ostrobe & (phase_q == '0);
  end

  // Divider, latched limit and phase state
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      cnt_q   <= '0;
      div_q   <= '0;
      phase_q <= '0;
    end else if (iclkena) begin
      cnt_q <= cnt_d;
      if (cnt_q == '0) div_q <= isps_div;
      if (ostrobe) phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/tcm_enc_sched.sv
// Packet scheduler in front of tcm_enc (4D-8PSK TCM): one source word per
// 4-sample slot, framed with sop/eop, code latched per packet.
// Optional statistics counters: define TCM_ENC_SCHED_STAT_EN.
module tcm_enc_sched
  import tcm_enc_sched_pkg::*;
#(
  parameter int unsigned pLEN_W = 16,
  parameter int unsigned pSPS_W = 8,
  parameter int unsigned pDAT_W = 11
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              irun,
  input  code_t             icode,
  input  logic [pLEN_W-1:0] ilen,
  input  logic [pSPS_W-1:0] isps_div,
  tcm_enc_sched_if.slave    bus,
  output logic              obusy,
  output logic              ounderrun,
  output logic [15:0]       opkt_cnt,
  output logic [15:0]       oudr_cnt
);

  logic              strobe, slot;
  logic              ordy, xfer, last;
  state_t            state_q;
  logic [pLEN_W-1:0] len_q, wcnt_q;
  code_t             code_q;
  logic              sps_q, val_q, sop_q, eop_q, udr_q;
  logic [pDAT_W-1:0] dat_q;

  tcm_sps_strobe #(.pSPS_W(pSPS_W)) u_sps (
    .iclk     (iclk),
    .ireset   (ireset),
    .iclkena  (iclkena),
    .isps_div (isps_div),
    .ostrobe  (strobe),
    .oslot    (slot)
  );

  // Source handshake and end-of-packet detect
  always_comb begin
    ordy = (state_q == RUN) & slot;
    xfer = ordy & bus.ival;
    last = (wcnt_q == len_q - pLEN_W'(1));
  end

  // Packet FSM with registered encoder-side outputs
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      code_q  <= '0;
      sps_q   <= 1'b0;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      udr_q   <= 1'b0;
      dat_q   <= '0;
    end else if (iclkena) begin
      sps_q <= strobe;
      val_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      udr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (irun && bus.ival && (ilen != '0)) begin
            len_q   <= ilen;
            code_q  <= icode;
            wcnt_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            val_q  <= 1'b1;
            dat_q  <= bus.idat;
            sop_q  <= (wcnt_q == '0);
            eop_q  <= last;
            wcnt_q <= wcnt_q + pLEN_W'(1);
            if (last) state_q <= IDLE;
          end else if (slot) begin
            udr_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ordy  = ordy;
  assign bus.ocode = code_q;
  assign bus.o1sps = sps_q;
  assign bus.oval  = val_q;
  assign bus.osop  = sop_q;
  assign bus.oeop  = eop_q;
  assign bus.odat  = dat_q;
  assign obusy     = (state_q == RUN);
  assign ounderrun = udr_q;

`ifdef TCM_ENC_SCHED_STAT_EN
  logic [15:0] pkt_q, udr_cnt_q;

  // Saturating statistics, updated together with the registered eop/underrun pulses
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      pkt_q     <= '0;
      udr_cnt_q <= '0;
    end else if (iclkena) begin
      if (xfer && last && (pkt_q != '1)) pkt_q <= pkt_q + 16'd1;
      if (ordy && !bus.ival && (udr_cnt_q != '1)) udr_cnt_q <= udr_cnt_q + 16'd1;
    end
  end

  assign opkt_cnt = pkt_q;
  assign oudr_cnt = udr_cnt_q;
`else
  assign opkt_cnt = '0;
  assign oudr_cnt = '0;
`endif

endmodule

// File: tb/tb_tcm_enc_sched.sv
// Directed self-checking bench for tcm_enc_sched.
module tb_tcm_enc_sched;
  import tcm_enc_sched_pkg::*;

`ifdef TCM_ENC_SCHED_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkena = 1'b1;
  logic        irun = 1'b0;
  code_t       icode = '0;
  logic [15:0] ilen = '0;
  logic [7:0]  sps = 8'd3;
  logic        obusy, ounderrun;
  logic [15:0] opkt, oudr;

  tcm_enc_sched_if #(.pDAT_W(11)) bus ();

  tcm_enc_sched #(.pLEN_W(16), .pSPS_W(8), .pDAT_W(11)) dut (
    .iclk      (clk),
    .ireset    (rst),
    .iclkena   (clkena),
    .irun      (irun),
    .icode     (icode),
    .ilen      (ilen),
    .isps_div  (sps),
    .bus       (bus),
    .obusy     (obusy),
    .ounderrun (ounderrun),
    .opkt_cnt  (opkt),
    .oudr_cnt  (oudr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  int         cyc = 0, n_val = 0, n_udr = 0, n_eop = 0, sps_prev = 0, sps_last = 0;
  logic [10:0] mv_dat [256];
  bit          mv_sop [256];
  bit          mv_eop [256];
  int          mv_cyc [256];
  code_t       mv_code [256];

  always @(negedge clk) begin
    cyc++;
    if (bus.oval && n_val < 256) begin
      mv_dat[n_val]  = bus.odat;
      mv_sop[n_val]  = bus.osop;
      mv_eop[n_val]  = bus.oeop;
      mv_cyc[n_val]  = cyc;
      mv_code[n_val] = bus.ocode;
      n_val++;
      if (bus.oeop) n_eop++;
    end
    if (ounderrun) n_udr++;
    if (bus.o1sps) begin
      sps_prev = sps_last;
      sps_last = cyc;
    end
  end

  // Source: advance the word after every accepted transfer
  initial begin
    bit x;
    bus.idat = 11'h100;
    forever begin
      @(negedge clk);
      #2;
      x = bus.ival & bus.ordy;
      @(posedge clk);
      #1;
      if (x) bus.idat = bus.idat + 11'd1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_val(input int target, input int budget, input string tag);
    int k = 0;
    while (n_val < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, (n_val >= target), 1);
  endtask

  task automatic wait_udr(input int target, input int budget, input string tag);
    int k = 0;
    while (n_udr < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, (n_udr >= target), 1);
  endtask

  function automatic logic [7:0] sop_vec(input int b, input int n);
    logic [7:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = mv_sop[b+i];
    return v;
  endfunction

  function automatic logic [7:0] eop_vec(input int b, input int n);
    logic [7:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = mv_eop[b+i];
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b, b2, ub, eb;
    logic [10:0] d0;
    bus.ival = 1'b0;

    // Reset state
    ticks(3);
    check("rst_busy", obusy, 0);
    check("rst_oval", bus.oval, 0);
    check("rst_o1sps", bus.o1sps, 0);
    check("rst_ocode", bus.ocode, 0);
    check("rst_pkt", opkt, 0);
    rst = 1'b0;

    // 1: isps_div=3, ilen=4, source always valid; irun dropped after first word
    sps = 8'd3; ilen = 16'd4; icode = 2'd1; bus.ival = 1'b1;
    b = n_val; d0 = bus.idat; irun = 1'b1;
    wait_val(b + 1, 100, "t1_start");
    irun = 1'b0;
    wait_val(b + 4, 200, "t1_done");
    ticks(40);
    check("t1_nval", n_val - b, 4);
    check("t1_sps_period", sps_last - sps_prev, 4);
    check("t1_slot_gap", mv_cyc[b+1] - mv_cyc[b], 16);
    check("t1_sop", sop_vec(b, 4), 8'h01);
    check("t1_eop", eop_vec(b, 4), 8'h08);
    for (int k = 0; k < 4; k++) check($sformatf("t1_dat%0d", k), mv_dat[b+k], d0 + 11'(k));
    check("t1_ocode", bus.ocode, 1);
    check("t1_busy", obusy, 0);

    // 2: isps_div=0, ilen=1, back-to-back single-word packets
    sps = 8'd0; ilen = 16'd1;
    b = n_val; irun = 1'b1;
    wait_val(b + 3, 100, "t2_done");
    irun = 1'b0;
    ticks(10);
    check("t2_nval", n_val - b, 3);
    check("t2_gap1", mv_cyc[b+1] - mv_cyc[b], 4);
    check("t2_gap2", mv_cyc[b+2] - mv_cyc[b+1], 4);
    check("t2_sop", sop_vec(b, 3), 8'h07);
    check("t2_eop", eop_vec(b, 3), 8'h07);
    check("t2_sps_period", sps_last - sps_prev, 1);
    check("t2_pkt_cnt", opkt, STAT ? 4 : 0);

    // 3: ilen=8 with ival dropped for two slots after word 2
    ilen = 16'd8;
    b = n_val; ub = n_udr; d0 = bus.idat; irun = 1'b1;
    wait_val(b + 1, 100, "t3_start");
    irun = 1'b0;
    wait_val(b + 3, 100, "t3_w3");
    bus.ival = 1'b0;
    wait_udr(ub + 2, 100, "t3_udr_wait");
    bus.ival = 1'b1;
    wait_val(b + 8, 200, "t3_done");
    ticks(20);
    check("t3_nudr", n_udr - ub, 2);
    check("t3_nval", n_val - b, 8);
    check("t3_gap", mv_cyc[b+3] - mv_cyc[b+2], 12);
    check("t3_sop", sop_vec(b, 8), 8'h01);
    check("t3_eop", eop_vec(b, 8), 8'h80);
    check("t3_dat7", mv_dat[b+7], d0 + 11'd7);
    check("t3_udr_cnt", oudr, STAT ? 2 : 0);
    check("t3_pkt_cnt", opkt, STAT ? 5 : 0);

    // 4: icode changes 1->3 mid-packet
    ilen = 16'd4; icode = 2'd1;
    b = n_val; irun = 1'b1;
    wait_val(b + 1, 100, "t4_start");
    irun = 1'b0;
    wait_val(b + 2, 100, "t4_w2");
    icode = 2'd3;
    wait_val(b + 4, 100, "t4_done");
    ticks(5);
    check("t4_code_words", {mv_code[b], mv_code[b+1], mv_code[b+2], mv_code[b+3]}, 8'h55);
    check("t4_code_held", bus.ocode, 1);
    b2 = n_val; irun = 1'b1;
    wait_val(b2 + 1, 100, "t4_next_start");
    irun = 1'b0;
    check("t4_next_code", mv_code[b2], 3);
    wait_val(b2 + 4, 100, "t4_next_done");

    // 5: irun deasserted after word 2 of a 5-word packet
    ilen = 16'd5;
    b = n_val; irun = 1'b1;
    wait_val(b + 3, 100, "t5_w3");
    irun = 1'b0;
    wait_val(b + 5, 100, "t5_done");
    ticks(30);
    check("t5_nval", n_val - b, 5);
    check("t5_sop", sop_vec(b, 5), 8'h01);
    check("t5_eop", eop_vec(b, 5), 8'h10);
    check("t5_busy", obusy, 0);
    check("t5_pkt_cnt", opkt, STAT ? 8 : 0);

    // ilen=0 never starts a packet
    ilen = 16'd0;
    b = n_val; irun = 1'b1;
    ticks(30);
    check("len0_nval", n_val - b, 0);
    check("len0_busy", obusy, 0);
    irun = 1'b0;

    // 6: ireset during RUN
    ilen = 16'd4;
    b = n_val; eb = n_eop; irun = 1'b1;
    wait_val(b + 2, 100, "t6_w2");
    rst = 1'b1;
    #1;
    check("t6_rst_busy", obusy, 0);
    check("t6_rst_oval", bus.oval, 0);
    check("t6_rst_odat", bus.odat, 0);
    check("t6_rst_ocode", bus.ocode, 0);
    check("t6_rst_ordy", bus.ordy, 0);
    check("t6_rst_pkt", opkt, 0);
    ticks(3);
    rst = 1'b0;
    b2 = n_val; d0 = bus.idat;
    wait_val(b2 + 1, 100, "t6_restart");
    irun = 1'b0;
    wait_val(b2 + 4, 100, "t6_done");
    ticks(10);
    check("t6_neop", n_eop - eb, 1);
    check("t6_sop", sop_vec(b2, 4), 8'h01);
    check("t6_eop", eop_vec(b2, 4), 8'h08);
    check("t6_dat0", mv_dat[b2], d0);
    check("t6_code", bus.ocode, 3);
    check("t6_pkt_cnt", opkt, STAT ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
